burt_v_window_sequencer: RTL and testbench
==========================================

Name: burt_v_window_sequencer

Overview:
- Line-buffer sequencer that feeds the vertical 5-tap binomial (1-4-6-4-1) filter stage. It takes a raster stream of signed 18-bit samples and emits one 5x1 vertical window per pixel, with the output row and column tagged.
- Applies clamp (edge-replicate) boundary handling at the top and bottom of the frame.
- After the last input row, it runs a flush phase that emits the final two output rows.
- Sits between the horizontal stage output and the vertical filter input.

Parameters:
- DATA_W, 18, sample width (signed, two's complement).
- MAX_WIDTH, 1024, line-buffer depth; the largest supported image width.

Ports:
- clk_i  input  1  clock.
- rst_i  input  1  asynchronous, active-high reset.
- width_i  input  16  image width W; sampled at frame start; valid range 1..MAX_WIDTH.
- height_i  input  16  image height H; sampled at frame start; valid range is 3 or more.
- data_i  input  DATA_W  input sample.
- col_i  input  16  input column.
- row_i  input  16  input row.
- valid_i  input  1  input beat valid.
- ready_o  output  1  sequencer accepts a beat.
- window_o  output  DATA_W x [5][1]  vertical window; index 0 is the topmost row.
- col_o  output  16  output column.
- row_o  output  16  output (centre) row.
- valid_o  output  1  window valid.
- busy_o  output  1  high whenever the state is not IDLE.

Behaviour:
- Reset, asynchronous: state=IDLE, valid_o=0, ready_o=1, busy_o=0, col_o=0, row_o=0, window_o all zero, internal counters=0. Line-buffer RAM contents are not cleared and are treated as don't-care.
- Accept condition: valid_i && ready_o. There is no downstream backpressure; the vertical filter always accepts.
- Line buffers: 4 buffers, each MAX_WIDTH x DATA_W, indexed by column. They hold the 4 most recent complete rows. Each accepted or flush beat reads all four at column c and writes the new sample at c.
- Window rule: for output row r and column c, window_o[k] = sample(clamp(r-2+k, 0, H-1), c) for k = 0..4.
- Latency: valid_o, window_o, col_o and row_o appear exactly 2 cycles after the accepted or flush beat that completes the window. The pipeline is fixed-length with no bubbles.
- State machine:
  - IDLE: ready_o=1. A beat with col_i=0 and row_i=0 latches W and H, is accepted into the buffers, and moves the state to FILL. Any other beat is accepted and discarded.
  - FILL: input rows 0 and 1 are stored and produce no output. On the last beat of row 1 (col W-1), move to STREAM.
  - STREAM: input row i (i = 2..H-1) produces output row i-2, one window per beat. On the beat with row H-1, col W-1, move to FLUSH.
  - FLUSH: ready_o=0. The sequencer generates 2*W internal beats, one per cycle, producing output rows H-2 and H-1. Rows past H-1 are replicated from row H-1. After the last flush beat, return to IDLE.
- Internal column and row counters track expected position. col wraps from W-1 to 0, and row increments on that wrap.
- Back-to-back frames: a col=0/row=0 beat arriving during FLUSH is blocked because ready_o=0. It is accepted on the first cycle back in IDLE.
- Width/height changes mid-frame have no effect; they are sampled only at frame start.
- Reset mid-frame: the frame is abandoned, any in-flight valid_o is dropped, and no partial flush occurs.
- Gaps (valid_i=0) stall the sequencer; no state change, no output.
- No arithmetic widening is performed; samples pass through unmodified at DATA_W bits.

Optional Feature:
- Macro: BURT_V_WINDOW_SEQUENCER_ERR_EN.
- When defined:
  - Adds output err_o (1 bit, reset 0).
  - err_o is sticky; it is set when an accepted beat in FILL or STREAM has col_i or row_i different from the internal expected counters.
  - It clears only at the next frame start in IDLE.
  - The sequencer continues using its internal counters regardless of the error.
- When undefined: err_o is absent and col_i/row_i are examined only in IDLE.

Test Plan:
- W=4, H=4, data = row*16+col, continuous valid. Expect 16 valid_o pulses: 8 during STREAM, then 8 during FLUSH. Output row 0 col 1 window = {1,1,1,17,33}. Row 3 col 2 window = {18,34,50,50,50}. ready_o is low for exactly 8 cycles.
- Minimum frame, W=1, H=3. Expect 3 outputs; row 1 window = {0,0,16,32,32}. Return to IDLE; busy_o=0.
- Random valid_i gaps, W=5, H=6. Expect windows identical to the gap-free run, each appearing 2 cycles after its completing beat.
- Two frames back-to-back, W=4, H=4. Frame 2's col0/row0 beat is held during FLUSH, accepted the first cycle after, and frame 2 outputs are correct.
- Assert rst_i mid-STREAM (row 2, col 1). Expect valid_o=0 immediately, state IDLE, and a subsequent clean frame to produce correct output.
- With ERR_EN defined, inject col_i=3 where 2 is expected. Expect err_o=1 held until the next frame start; windows unaffected.

Source files
------------

// File: rtl/burt_v_window_sequencer_if.sv
// Stream-side bundle of burt_v_window_sequencer: raster sample input and vertical window output.
// slave is the sequencer's view; master is the upstream source / downstream sink view.
interface burt_v_window_sequencer_if #(
  parameter int DATA_W = 18
) ();
  logic [DATA_W-1:0]      data_i;
  logic [15:0]            col_i;
  logic [15:0]            row_i;
  logic                   valid_i;
  logic                   ready_o;
  logic [4:0][DATA_W-1:0] window_o;
  logic [15:0]            col_o;
  logic [15:0]            row_o;
  logic                   valid_o;

  modport slave (
    input  data_i, col_i, row_i, valid_i,
    output ready_o, window_o, col_o, row_o, valid_o
  );

  modport master (
    output data_i, col_i, row_i, valid_i,
    input  ready_o, window_o, col_o, row_o, valid_o
  );
endinterface

// File: rtl/burt_v_window_sequencer.sv
// Line-buffer sequencer emitting clamped 5x1 vertical windows for the 1-4-6-4-1 vertical stage.
// Optional sticky position-error flag err_o is built when BURT_V_WINDOW_SEQUENCER_ERR_EN is defined.
module burt_v_window_sequencer #(
  parameter int DATA_W    = 18,
  parameter int MAX_WIDTH = 1024
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [15:0] width_i,
  input  logic [15:0] height_i,
  burt_v_window_sequencer_if.slave s_if,
  output logic        busy_o,
  output logic [1:0]  state_o
`ifdef BURT_V_WINDOW_SEQUENCER_ERR_EN
  ,
  output logic        err_o
`endif
);

  localparam int AW = (MAX_WIDTH > 1) ? $clog2(MAX_WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, FILL, STREAM, FLUSH} state_t;

  state_t state_q, state_d;

  logic [15:0] w_q, h_q, col_q, row_q;
  logic [15:0] eff_w, eff_h;
  logic        last_col, sof, beat, ready;
  logic [AW-1:0] addr;
  logic [DATA_W-1:0] wr_data, rd0, rd1, rd2, rd3;

  // lb0 holds the most recent stored row, lb3 the oldest
  logic [DATA_W-1:0] lb0 [MAX_WIDTH];
  logic [DATA_W-1:0] lb1 [MAX_WIDTH];
  logic [DATA_W-1:0] lb2 [MAX_WIDTH];
  logic [DATA_W-1:0] lb3 [MAX_WIDTH];

  logic                   s1_valid;
  logic [15:0]            s1_col, s1_row;
  logic [4:0][DATA_W-1:0] s1_tap;
  logic [4:0][DATA_W-1:0] win_d;

  // Handshake: a beat transfers on a cycle where valid_i && ready_o; ready_o depends only on state,
  // never on valid_i. The output side has no backpressure: valid_o marks a window for one cycle.
  assign eff_w    = (state_q == IDLE) ? width_i  : w_q;
  assign eff_h    = (state_q == IDLE) ? height_i : h_q;
  assign last_col = (col_q == eff_w - 16'd1);
  assign sof      = s_if.valid_i && (s_if.col_i == 16'd0) && (s_if.row_i == 16'd0);
  assign addr     = col_q[AW-1:0];

  assign rd0 = lb0[addr];
  assign rd1 = lb1[addr];
  assign rd2 = lb2[addr];
  assign rd3 = lb3[addr];

  // During flush the newest row is replicated, which yields the bottom clamp for free
  assign wr_data = (state_q == FLUSH) ? rd0 : s_if.data_i;

  always_comb begin
    state_d = state_q;
    beat    = 1'b0;
    ready   = 1'b1;
    case (state_q)
      IDLE: begin
        beat = sof;
        if (sof) state_d = FILL;
      end
      FILL: begin
        beat = s_if.valid_i;
        if (beat && last_col && (row_q == 16'd1)) state_d = STREAM;
      end
      STREAM: begin
        beat = s_if.valid_i;
        if (beat && last_col && (row_q == eff_h - 16'd1)) state_d = FLUSH;
      end
      FLUSH: begin
        ready = 1'b0;
        beat  = 1'b1;
        if (last_col && (row_q == h_q + 16'd1)) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      w_q     <= '0;
      h_q     <= '0;
      col_q   <= '0;
      row_q   <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && beat) begin
        w_q <= width_i;
        h_q <= height_i;
      end
      if (beat) begin
        if (state_d == IDLE) begin
          col_q <= '0;
          row_q <= '0;
        end else if (last_col) begin
          col_q <= '0;
          row_q <= row_q + 16'd1;
        end else begin
          col_q <= col_q + 16'd1;
        end
      end
    end
  end

  // Each beat shifts the column down through the four row buffers
  always_ff @(posedge clk_i) begin
    if (beat) begin
      lb0[addr] <= wr_data;
      lb1[addr] <= rd0;
      lb2[addr] <= rd1;
      lb3[addr] <= rd2;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      s1_valid <= 1'b0;
      s1_col   <= '0;
      s1_row   <= '0;
      s1_tap   <= '0;
    end else begin
      s1_valid <= beat && (row_q >= 16'd2);
      if (beat) begin
        s1_col <= col_q;
        s1_row <= row_q;
        s1_tap <= {rd3, rd2, rd1, rd0, wr_data};
      end
    end
  end

  // Tap n holds row (s1_row - n); top clamp substitutes row 0, which is tap s1_row
  always_comb begin
    win_d = '0;
    for (int k = 0; k < 5; k++) begin
      if (s1_row < 16'(4 - k)) win_d[k] = s1_tap[s1_row[2:0]];
      else                     win_d[k] = s1_tap[4 - k];
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      s_if.valid_o  <= 1'b0;
      s_if.col_o    <= '0;
      s_if.row_o    <= '0;
      s_if.window_o <= '0;
    end else begin
      s_if.valid_o <= s1_valid;
      if (s1_valid) begin
        s_if.col_o    <= s1_col;
        s_if.row_o    <= s1_row - 16'd2;
        s_if.window_o <= win_d;
      end
    end
  end

  assign s_if.ready_o = ready;
  assign busy_o       = (state_q != IDLE);
  assign state_o      = state_q;

`ifdef BURT_V_WINDOW_SEQUENCER_ERR_EN
  logic err_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      err_q <= 1'b0;
    end else if (state_q == IDLE && beat) begin
      err_q <= 1'b0;
    end else if ((state_q == FILL || state_q == STREAM) && beat &&
                 ((s_if.col_i != col_q) || (s_if.row_i != row_q))) begin
      err_q <= 1'b1;
    end
  end

  assign err_o = err_q;
`endif

endmodule

// File: tb/tb_burt_v_window_sequencer.sv
// Directed bench for burt_v_window_sequencer: frames of known samples, windows checked
// against a clamp model in an expected queue, including cycle of arrival.
module tb_burt_v_window_sequencer;

  localparam int EW = 48 + 5 * 18;

  logic        clk_i;
  logic        rst_i;
  logic [15:0] width_i;
  logic [15:0] height_i;
  logic        busy_o;
  logic [1:0]  state_o;
`ifdef BURT_V_WINDOW_SEQUENCER_ERR_EN
  logic        err_o;
`endif

  burt_v_window_sequencer_if #(.DATA_W(18)) bus ();

  burt_v_window_sequencer #(.DATA_W(18), .MAX_WIDTH(1024)) dut (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .width_i  (width_i),
    .height_i (height_i),
    .s_if     (bus),
    .busy_o   (busy_o),
    .state_o  (state_o)
`ifdef BURT_V_WINDOW_SEQUENCER_ERR_EN
    ,
    .err_o    (err_o)
`endif
  );

  // clock / cycle counter
  int cyc = 0;
  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end
  always @(posedge clk_i) cyc <= cyc + 1;

  initial begin
    #400000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  // scoreboard state
  logic [EW-1:0]    exp_q[$];
  logic [4:0][17:0] cap [8][8];
  int checks = 0;
  int fails = 0;
  int out_cnt = 0;
  int ready_low_cnt = 0;

  function automatic logic [17:0] smp(input int tag, input int r, input int c);
    return 18'(tag * 256 + r * 16 + c);
  endfunction

  function automatic logic [EW-1:0] mk_rec(input int cy, input int r, input int c,
                                           input int tag, input int h);
    logic [4:0][17:0] w;
    int rr;
    for (int k = 0; k < 5; k++) begin
      rr = r - 2 + k;
      if (rr < 0) rr = 0;
      if (rr > h - 1) rr = h - 1;
      w[k] = smp(tag, rr, c);
    end
    return {16'(cy), 16'(r), 16'(c), w};
  endfunction

  task automatic chk(input string tag, input logic [EW-1:0] obs, input logic [EW-1:0] expv);
    checks++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic monitor();
    logic [EW-1:0] got;
    logic [EW-1:0] ev;
    forever begin
      @(negedge clk_i);
      if (!rst_i && bus.ready_o === 1'b0) ready_low_cnt++;
      if (bus.valid_o === 1'b1) begin
        out_cnt++;
        got = {cyc[15:0], bus.row_o, bus.col_o, bus.window_o};
        if (bus.row_o < 16'd8 && bus.col_o < 16'd8)
          cap[bus.row_o[2:0]][bus.col_o[2:0]] = bus.window_o;
        if (exp_q.size() == 0) begin
          checks++;
          fails++;
          $error("FAIL unexpected_window: observed=%0h expected=none", got);
        end else begin
          ev = exp_q.pop_front();
          chk("window", got, ev);
        end
      end
    end
  endtask

  // driver tasks
  task automatic drive_beat(input logic [17:0] d, input int c, input int r, output int acc_cyc);
    int budget;
    budget = 0;
    bus.data_i  = d;
    bus.col_i   = 16'(c);
    bus.row_i   = 16'(r);
    bus.valid_i = 1'b1;
    while (bus.ready_o !== 1'b1 && budget < 200) begin
      @(posedge clk_i); #1;
      budget++;
    end
    if (bus.ready_o !== 1'b1) begin
      checks++;
      fails++;
      $error("FAIL ready_timeout: observed=0 expected=1");
      acc_cyc = -1;
    end else begin
      acc_cyc = cyc;
    end
    @(posedge clk_i); #1;
    bus.valid_i = 1'b0;
  endtask

  task automatic send_frame(input int w, input int h, input int tag, input bit gaps,
                            input int bad_r, output int first_drv, output int last_drv);
    int dc;
    int rc;
    first_drv = 0;
    last_drv  = 0;
    width_i   = 16'(w);
    height_i  = 16'(h);
    for (int r = 0; r < h; r++) begin
      for (int c = 0; c < w; c++) begin
        if (gaps) begin
          repeat ($urandom_range(0, 2)) begin
            @(posedge clk_i); #1;
          end
        end
        rc = (r == bad_r && c == 2) ? 3 : c;
        drive_beat(smp(tag, r, c), rc, r, dc);
        if (r == 0 && c == 0) begin
          first_drv = dc;
          width_i   = 16'd7;
          height_i  = 16'd9;
        end
        if (r >= 2) exp_q.push_back(mk_rec(dc + 2, r - 2, c, tag, h));
        last_drv = dc;
      end
    end
    for (int j = 0; j < 2 * w; j++)
      exp_q.push_back(mk_rec(last_drv + 3 + j, h - 2 + j / w, j % w, tag, h));
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy_o === 1'b1 && n < 500) begin
      @(posedge clk_i); #1;
      n++;
    end
    if (busy_o !== 1'b0) begin
      checks++;
      fails++;
      $error("FAIL idle_timeout: observed busy=%b expected=0", busy_o);
    end
    repeat (3) begin
      @(posedge clk_i); #1;
    end
  endtask

  // directed sequence
  initial begin
    int f1, l1, f2, l2, dc, oc0, rl0;
    rst_i       = 1'b1;
    width_i     = '0;
    height_i    = '0;
    bus.data_i  = '0;
    bus.col_i   = '0;
    bus.row_i   = '0;
    bus.valid_i = 1'b0;
    fork
      monitor();
    join_none

    repeat (3) @(posedge clk_i);
    #1;
    chk("rst_valid_o", EW'(bus.valid_o), EW'(0));
    chk("rst_ready_o", EW'(bus.ready_o), EW'(1));
    chk("rst_busy_o", EW'(busy_o), EW'(0));
    chk("rst_state", EW'(state_o), EW'(0));
    chk("rst_col_o", EW'(bus.col_o), EW'(0));
    chk("rst_row_o", EW'(bus.row_o), EW'(0));
    chk("rst_window_o", EW'(bus.window_o), EW'(0));
`ifdef BURT_V_WINDOW_SEQUENCER_ERR_EN
    chk("rst_err_o", EW'(err_o), EW'(0));
`endif
    rst_i = 1'b0;
    @(posedge clk_i); #1;

    // non-start beat in IDLE is discarded
    width_i  = 16'd4;
    height_i = 16'd4;
    drive_beat(18'd99, 2, 1, dc);
    chk("idle_discard_state", EW'(state_o), EW'(0));
    chk("idle_discard_busy", EW'(busy_o), EW'(0));

    // W=4 H=4 continuous
    oc0 = out_cnt;
    rl0 = ready_low_cnt;
    send_frame(4, 4, 0, 1'b0, -1, f1, l1);
    wait_idle();
    chk("w4h4_out_count", EW'(out_cnt - oc0), EW'(16));
    chk("w4h4_ready_low", EW'(ready_low_cnt - rl0), EW'(8));
    chk("w4h4_r0c1", EW'(cap[0][1]), EW'({18'd33, 18'd17, 18'd1, 18'd1, 18'd1}));
    chk("w4h4_r3c2", EW'(cap[3][2]), EW'({18'd50, 18'd50, 18'd50, 18'd34, 18'd18}));
    chk("w4h4_drained", EW'(exp_q.size()), EW'(0));

    // minimum frame W=1 H=3
    oc0 = out_cnt;
    send_frame(1, 3, 0, 1'b0, -1, f1, l1);
    wait_idle();
    chk("w1h3_out_count", EW'(out_cnt - oc0), EW'(3));
    chk("w1h3_r1c0", EW'(cap[1][0]), EW'({18'd32, 18'd32, 18'd16, 18'd0, 18'd0}));
    chk("w1h3_busy", EW'(busy_o), EW'(0));
    chk("w1h3_state", EW'(state_o), EW'(0));

    // random gaps W=5 H=6
    oc0 = out_cnt;
    send_frame(5, 6, 0, 1'b1, -1, f1, l1);
    wait_idle();
    chk("gaps_out_count", EW'(out_cnt - oc0), EW'(30));
    chk("gaps_drained", EW'(exp_q.size()), EW'(0));

    // back-to-back frames, second start held off by FLUSH
    oc0 = out_cnt;
    send_frame(4, 4, 1, 1'b0, -1, f1, l1);
    send_frame(4, 4, 2, 1'b0, -1, f2, l2);
    chk("b2b_start_cycle", EW'(f2 - l1), EW'(9));
    wait_idle();
    chk("b2b_out_count", EW'(out_cnt - oc0), EW'(32));
    chk("b2b_drained", EW'(exp_q.size()), EW'(0));

    // reset mid-STREAM after beat (row 2, col 1)
    width_i  = 16'd4;
    height_i = 16'd4;
    for (int i = 0; i < 10; i++) drive_beat(smp(3, i / 4, i % 4), i % 4, i / 4, dc);
    chk("pre_rst_valid", EW'(bus.valid_o), EW'(1));
    exp_q.delete();
    rst_i = 1'b1;
    #1;
    chk("mid_rst_valid", EW'(bus.valid_o), EW'(0));
    chk("mid_rst_state", EW'(state_o), EW'(0));
    chk("mid_rst_busy", EW'(busy_o), EW'(0));
    chk("mid_rst_ready", EW'(bus.ready_o), EW'(1));
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    @(posedge clk_i); #1;
    oc0 = out_cnt;
    send_frame(4, 4, 4, 1'b0, -1, f1, l1);
    wait_idle();
    chk("post_rst_out_count", EW'(out_cnt - oc0), EW'(16));
    chk("post_rst_drained", EW'(exp_q.size()), EW'(0));

`ifdef BURT_V_WINDOW_SEQUENCER_ERR_EN
    // position error: col 3 reported where 2 is expected on row 1
    oc0 = out_cnt;
    send_frame(4, 4, 5, 1'b0, 1, f1, l1);
    wait_idle();
    chk("err_set", EW'(err_o), EW'(1));
    chk("err_out_count", EW'(out_cnt - oc0), EW'(16));
    repeat (4) begin
      @(posedge clk_i); #1;
    end
    chk("err_sticky", EW'(err_o), EW'(1));
    send_frame(4, 4, 6, 1'b0, -1, f1, l1);
    wait_idle();
    chk("err_cleared", EW'(err_o), EW'(0));
    chk("err_drained", EW'(exp_q.size()), EW'(0));
`endif

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
